// File: rtl/hpu_lsu_bypass_net.sv
// LSU operand bypass network: live and history result forwarding
// behind a registered valid/ready stage that keeps resolving while stalled.
module hpu_lsu_bypass_net #(
  parameter int SRC_NUM    = 2,
  parameter int PORT_NUM   = 2,
  parameter int HIST_DEPTH = 2,
  parameter int DATA_W     = 32,
  parameter int IDX_W      = 7,
  parameter int ZERO_EN    = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [SRC_NUM-1:0]           src_en_i,
  input  logic [SRC_NUM*IDX_W-1:0]     src_idx_i,
  input  logic [SRC_NUM*DATA_W-1:0]    src_data_i,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [PORT_NUM*IDX_W-1:0]    rf_idx_i,
  input  logic [PORT_NUM*DATA_W-1:0]   rf_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [PORT_NUM*DATA_W-1:0]   op_data_o,
  output logic [PORT_NUM-1:0]          op_hit_o
);

  localparam logic ZERO_ON = (ZERO_EN != 0);

  logic [SRC_NUM-1:0][IDX_W-1:0]   live_idx;
  logic [SRC_NUM-1:0][DATA_W-1:0]  live_data;
  logic [PORT_NUM-1:0][IDX_W-1:0]  port_idx;
  logic [PORT_NUM-1:0][DATA_W-1:0] port_rf;

  assign live_idx  = src_idx_i;
  assign live_data = src_data_i;
  assign port_idx  = rf_idx_i;
  assign port_rf   = rf_data_i;

  logic [SRC_NUM-1:0]              h_en   [HIST_DEPTH];
  logic [SRC_NUM-1:0][IDX_W-1:0]   h_idx  [HIST_DEPTH];
  logic [SRC_NUM-1:0][DATA_W-1:0]  h_data [HIST_DEPTH];

  logic [PORT_NUM-1:0][DATA_W-1:0] res_data;
  logic [PORT_NUM-1:0]             res_hit;
  logic [PORT_NUM-1:0]             found;

  logic [PORT_NUM-1:0][DATA_W-1:0] hold_data;
  logic [PORT_NUM-1:0][IDX_W-1:0]  hold_idx;
  logic [PORT_NUM-1:0]             hold_hit;
  logic                            out_valid;
  logic                            accept;

  assign in_ready_o  = !out_valid | out_ready_i;
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = out_valid;
  assign op_data_o   = hold_data;
  assign op_hit_o    = hold_hit;

  // Priority: zero reg, live sources, then history youngest first.
  always_comb begin
    res_data = port_rf;
    res_hit  = '0;
    found    = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (ZERO_ON && port_idx[p] == '0) begin
        res_data[p] = '0;
        found[p]    = 1'b1;
      end
      for (int s = 0; s < SRC_NUM; s++) begin
        if (!found[p] && src_en_i[s] &&
            live_idx[s] == port_idx[p]) begin
          res_data[p] = live_data[s];
          res_hit[p]  = 1'b1;
          found[p]    = 1'b1;
        end
      end
      for (int k = 0; k < HIST_DEPTH; k++) begin
        for (int s = 0; s < SRC_NUM; s++) begin
          if (!found[p] && h_en[k][s] &&
              h_idx[k][s] == port_idx[p]) begin
            res_data[p] = h_data[k][s];
            res_hit[p]  = 1'b1;
            found[p]    = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int k = 0; k < HIST_DEPTH; k++) h_en[k] <= '0;
    end else if (flush_i) begin
      for (int k = 0; k < HIST_DEPTH; k++) h_en[k] <= '0;
    end else begin
      h_en[0] <= src_en_i;
      for (int k = 1; k < HIST_DEPTH; k++) h_en[k] <= h_en[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    h_idx[0]  <= live_idx;
    h_data[0] <= live_data;
    for (int k = 1; k < HIST_DEPTH; k++) begin
      h_idx[k]  <= h_idx[k-1];
      h_data[k] <= h_data[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      out_valid <= 1'b0;
      hold_data <= '0;
      hold_idx  <= '0;
      hold_hit  <= '0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      hold_data <= res_data;
      hold_idx  <= port_idx;
      hold_hit  <= res_hit;
    end else if (out_valid && out_ready_i) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      // Descending scan so the lowest matching source is the last write.
      for (int p = 0; p < PORT_NUM; p++) begin
        for (int s = SRC_NUM - 1; s >= 0; s--) begin
          if (src_en_i[s] && live_idx[s] == hold_idx[p] &&
              !(ZERO_ON && hold_idx[p] == '0)) begin
            hold_data[p] <= live_data[s];
            hold_hit[p]  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hpu_lsu_bypass_net.sv
// Scoreboard bench for hpu_lsu_bypass_net: directed vectors,
// expected operands queued at issue, checked by a monitor on transfer.
module tb_hpu_lsu_bypass_net;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  src_en;
  logic [13:0] src_idx;
  logic [63:0] src_data;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] rf_idx;
  logic [63:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] op_data;
  logic [1:0]  op_hit;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  hit;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hpu_lsu_bypass_net dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .src_en_i    (src_en),
    .src_idx_i   (src_idx),
    .src_data_i  (src_data),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .rf_idx_i    (rf_idx),
    .rf_data_i   (rf_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .op_data_o   (op_data),
    .op_hit_o    (op_hit)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("op_data", op_data, e.data);
        chk("op_hit", {62'd0, op_hit}, {62'd0, e.hit});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    in_valid = 1'b0;
    src_en   = 2'b00;
    flush    = 1'b0;
  endtask

  task automatic set_src(input int s, input logic [6:0] idx,
                         input logic [31:0] d);
    src_en[s]          = 1'b1;
    src_idx[s*7 +: 7]  = idx;
    src_data[s*32 +: 32] = d;
  endtask

  task automatic issue(input logic [6:0] i0, input logic [31:0] d0,
                       input logic [6:0] i1, input logic [31:0] d1,
                       input logic [63:0] ed, input logic [1:0] eh,
                       input bit push);
    exp_t e;
    in_valid = 1'b1;
    rf_idx   = {i1, i0};
    rf_data  = {d1, d0};
    e.data   = ed;
    e.hit    = eh;
    if (push) q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; out_ready = 1'b1;
    src_idx = '0; src_data = '0; rf_idx = '0; rf_data = '0;
    clear();
    step(); step();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_data", op_data, 64'd0);
    chk("rst_hit", {62'd0, op_hit}, 64'd0);
    rst = 1'b1;
    step();

    // live priority: src0 beats src1 on same index
    set_src(0, 7'd5, 32'hAAAA);
    set_src(1, 7'd5, 32'hBBBB);
    issue(7'd5, 32'h1111, 7'd7, 32'h2222,
          {32'h2222, 32'hAAAA}, 2'b01, 1);
    step(); clear(); step(); step(); step();

    // history age
    set_src(1, 7'd9, 32'h1234);
    step(); clear();
    issue(7'd9, 32'h0, 7'd0, 32'h55, {32'h0, 32'h1234}, 2'b01, 1);
    step();
    issue(7'd9, 32'h9999, 7'd2, 32'h22, {32'h22, 32'h1234}, 2'b01, 1);
    step();
    issue(7'd9, 32'h4321, 7'd2, 32'h22, {32'h22, 32'h4321}, 2'b00, 1);
    step(); clear(); step(); step();

    // zero register live and via history
    set_src(0, 7'd0, 32'hFFFF);
    issue(7'd0, 32'h55, 7'd1, 32'h66, {32'h66, 32'h0}, 2'b00, 1);
    step(); clear();
    issue(7'd0, 32'h55, 7'd0, 32'h77, {32'h0, 32'h0}, 2'b00, 1);
    step(); clear(); step(); step();

    // stall refresh
    out_ready = 1'b0;
    issue(7'd12, 32'h0, 7'd13, 32'h13, {32'h13, 32'hCAFE}, 2'b01, 1);
    step(); clear();
    chk("stall_ready", {63'd0, in_ready}, 64'd0);
    chk("stall_valid", {63'd0, out_valid}, 64'd1);
    step();
    set_src(0, 7'd12, 32'hCAFE);
    set_src(1, 7'd14, 32'hBAD);
    step(); clear();
    chk("stall_ready2", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    step(); step();

    // flush drops input and history
    set_src(0, 7'd3, 32'h77);
    step(); clear();
    flush = 1'b1;
    issue(7'd3, 32'h99, 7'd4, 32'h44, 64'd0, 2'b00, 0);
    step(); clear();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    issue(7'd3, 32'h10, 7'd4, 32'h44, {32'h44, 32'h10}, 2'b00, 1);
    step(); clear(); step(); step();

    // reset mid-stall
    out_ready = 1'b0;
    set_src(0, 7'd40, 32'h4040);
    issue(7'd30, 32'hABCD, 7'd31, 32'h0, 64'd0, 2'b00, 0);
    step(); clear();
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b0;
    step();
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_data", op_data, 64'd0);
    chk("mid_rst_hit", {62'd0, op_hit}, 64'd0);
    chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b1;
    out_ready = 1'b1;
    issue(7'd40, 32'h1, 7'd41, 32'h2, {32'h2, 32'h1}, 2'b00, 1);
    step(); clear();
    repeat (4) step();

    chk("queue_drained", q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
